// File: rtl/clahe_ram_pkg.sv
// Shared definitions for the CLAHE histogram RAM front end: sequencer state
// encoding, requester ids and the read-latency helper.
package clahe_ram_pkg;

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Address/command register plus the RAM array stage; the optional RAM
    // output register adds one more.
    localparam int RD_LAT_BASE = 2;

    function automatic int rd_latency(input int output_reg);
        return RD_LAT_BASE + output_reg;
    endfunction

endpackage

// File: rtl/sprom_rd_tag_pipe.sv
// Read-return tag pipe: shifts {valid,id} of each issued read so the return
// lines up with RAM data, and reports when nothing is in flight.
module sprom_rd_tag_pipe
    import clahe_ram_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id,
    output logic empty
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] id;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            id  <= '0;
        end else begin
            vld <= {vld[DEPTH-2:0], in_valid};
            id  <= {id[DEPTH-2:0], in_id};
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_id    = id[DEPTH-1];
    // Includes the output stage so a DRAIN never leaves before the last return is shown.
    assign empty     = ~|vld;

endmodule

// File: rtl/sprom_port_arbiter.sv
// Two-requester front end for a single-port BRAM with in-order read returns
// and a built-in sweep that writes CLEAR_VALUE to every address.
module sprom_port_arbiter
    import clahe_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int BYTEEN_WIDTH = 2,
    parameter int OUTPUT_REG   = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_start,
    output logic                    clr_busy,
    output logic                    clr_done,
    input  logic                    r0_valid,
    output logic                    r0_ready,
    input  logic                    r0_we,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    input  logic [BYTEEN_WIDTH-1:0] r0_byteen,
    output logic                    r0_rvalid,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    input  logic                    r1_valid,
    output logic                    r1_ready,
    input  logic                    r1_we,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    input  logic [BYTEEN_WIDTH-1:0] r1_byteen,
    output logic                    r1_rvalid,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic                    ram_wclke,
    output logic                    ram_we,
    output logic                    ram_re,
    output logic                    ram_addren,
    output logic                    ram_rst,
    output logic [BYTEEN_WIDTH-1:0] ram_byteen,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int RD_LAT = rd_latency(OUTPUT_REG);

    logic [1:0]              state;
    logic                    last_grant;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    serve;
    logic                    accept;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [BYTEEN_WIDTH-1:0] sel_byteen;
    logic                    tag_valid;
    logic                    tag_id;
    logic                    pipe_empty;

    // valid/ready: a command transfers in a cycle where valid && ready; ready
    // never depends on a registered copy of valid and only one side gets it.
    always_comb begin
        serve      = (state == ST_SERVE);
        r0_ready   = serve && r0_valid && (!r1_valid || last_grant == REQ1);
        r1_ready   = serve && r1_valid && (!r0_valid || last_grant == REQ0);
        accept     = r0_ready || r1_ready;
        sel_we     = r1_ready ? r1_we     : r0_we;
        sel_addr   = r1_ready ? r1_addr   : r0_addr;
        sel_wdata  = r1_ready ? r1_wdata  : r0_wdata;
        sel_byteen = r1_ready ? r1_byteen : r0_byteen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SERVE;
            last_grant <= REQ1;
            clr_cnt    <= '0;
            clr_done   <= 1'b0;
            ram_wclke  <= 1'b0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            ram_addren <= 1'b0;
            ram_byteen <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_rst    <= 1'b1;
        end else begin
            ram_rst    <= 1'b0;
            clr_done   <= 1'b0;
            ram_wclke  <= 1'b0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            ram_addren <= 1'b0;
            ram_byteen <= '0;
            case (state)
                ST_SERVE: begin
                    if (accept) begin
                        ram_addren <= 1'b1;
                        ram_re     <= !sel_we;
                        ram_we     <= sel_we;
                        ram_wclke  <= sel_we;
                        ram_byteen <= sel_we ? sel_byteen : '0;
                        ram_addr   <= sel_addr;
                        if (sel_we) ram_wdata <= sel_wdata;
                        last_grant <= r1_ready ? REQ1 : REQ0;
                    end
                    if (clr_start) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    ram_addren <= 1'b1;
                    ram_we     <= 1'b1;
                    ram_wclke  <= 1'b1;
                    ram_byteen <= '1;
                    ram_addr   <= clr_cnt;
                    ram_wdata  <= CLEAR_VALUE;
                    // Stop at the top address rather than wrapping back to 0.
                    if (&clr_cnt) begin
                        state    <= ST_SERVE;
                        clr_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= ST_SERVE;
            endcase
        end
    end

    sprom_rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept && !sel_we),
        .in_id     (r1_ready ? REQ1 : REQ0),
        .out_valid (tag_valid),
        .out_id    (tag_id),
        .empty     (pipe_empty)
    );

    assign clr_busy  = (state != ST_SERVE);
    assign r0_rvalid = tag_valid && (tag_id == REQ0);
    assign r1_rvalid = tag_valid && (tag_id == REQ1);
    assign r0_rdata  = ram_rdata;
    assign r1_rdata  = ram_rdata;

endmodule

// File: tb/tb_sprom_port_arbiter.sv
// Bench for sprom_port_arbiter: behavioural RAM, a transaction-level reference
// model checked every cycle, and directed plus random stimulus.
module tb_sprom_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BW = 2;
    localparam int LAT = 3;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] CLR_VAL = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_start = 1'b0;
    logic clr_busy, clr_done;
    logic r0_valid = 1'b0, r0_we = 1'b0, r1_valid = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic [BW-1:0] r0_byteen = '0, r1_byteen = '0;
    logic r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic ram_wclke, ram_we, ram_re, ram_addren, ram_rst;
    logic [BW-1:0] ram_byteen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    sprom_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(BW), .OUTPUT_REG(1), .CLEAR_VALUE(CLR_VAL)
    ) dut (
        .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_byteen(r0_byteen), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_byteen(r1_byteen), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_wclke(ram_wclke), .ram_we(ram_we), .ram_re(ram_re), .ram_addren(ram_addren),
        .ram_rst(ram_rst), .ram_byteen(ram_byteen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // clock
    always #5 clk = ~clk;

    // Behavioural single-port RAM with array stage plus output register.
    logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
    logic [DW-1:0] ram_q1 = '0;
    always @(posedge clk) begin
        if (ram_addren === 1'b1 && ram_wclke === 1'b1 && ram_we === 1'b1)
            for (int b = 0; b < BW; b++)
                if (ram_byteen[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_addren === 1'b1 && ram_re === 1'b1) ram_q1 <= ram_mem[ram_addr];
        ram_rdata <= ram_q1;
    end

    // Reference model state.
    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    logic [48:0] exp_q[$];          // {due cycle, requester id, data}
    logic model_last = 1'b1;
    int clr_s = 1 << 30;
    int clr_c = -1000;
    logic nx_valid = 1'b0, nx_we = 1'b0;
    logic [AW-1:0] nx_addr = '0;
    logic [DW-1:0] nx_wdata = '0;
    logic [BW-1:0] nx_byteen = '0;
    logic prev_rst = 1'b0;
    logic checks_on = 1'b0;
    logic g0 = 1'b0, g1 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic observe();
        logic busy, e0, e1, hd, hid;
        logic [DW-1:0] hdat;
        int k, maxdue;
        busy = (cyc > clr_s) && (cyc <= clr_c + 16);
        e0 = !busy && r0_valid && (!r1_valid || model_last);
        e1 = !busy && r1_valid && (!r0_valid || !model_last);
        g0 = r0_ready;
        g1 = r1_ready;
        if (checks_on) begin
            chk("r0_ready", r0_ready, e0);
            chk("r1_ready", r1_ready, e1);
            chk("clr_busy", clr_busy, busy);
            chk("clr_done", clr_done, cyc == clr_c + 17);
            chk("ram_rst", ram_rst, prev_rst);
            if (cyc >= clr_c + 2 && cyc <= clr_c + 17) begin
                k = cyc - (clr_c + 2);
                chk("clr_ctl", {ram_addren, ram_re, ram_we, ram_wclke, ram_byteen}, {4'b1011, {BW{1'b1}}});
                chk("clr_addr", ram_addr, k[AW-1:0]);
                chk("clr_data", ram_wdata, CLR_VAL);
                ref_mem[k] = CLR_VAL;
            end else if (nx_valid) begin
                chk("cmd_ctl", {ram_addren, ram_re, ram_we, ram_wclke, ram_byteen},
                    {1'b1, !nx_we, nx_we, nx_we, nx_we ? nx_byteen : {BW{1'b0}}});
                chk("cmd_addr", ram_addr, nx_addr);
                if (nx_we) chk("cmd_wdata", ram_wdata, nx_wdata);
            end else begin
                chk("idle_ctl", {ram_addren, ram_re, ram_we, ram_wclke, ram_byteen}, 0);
            end
            hd = (exp_q.size() > 0) && (int'(exp_q[0][48:17]) == cyc);
            hid = hd ? exp_q[0][16] : 1'b0;
            hdat = hd ? exp_q[0][15:0] : '0;
            chk("r0_rvalid", r0_rvalid, hd && !hid);
            chk("r1_rvalid", r1_rvalid, hd && hid);
            if (hd) begin
                chk(hid ? "r1_rdata" : "r0_rdata", hid ? r1_rdata : r0_rdata, hdat);
                void'(exp_q.pop_front());
            end
        end
        nx_valid = 1'b0;
        if (rst) begin
            exp_q.delete();
            model_last = 1'b1;
            clr_s = 1 << 30;
            clr_c = -1000;
            checks_on = 1'b1;
        end else begin
            if (e0 || e1) begin
                nx_valid = 1'b1;
                nx_we = e1 ? r1_we : r0_we;
                nx_addr = e1 ? r1_addr : r0_addr;
                nx_wdata = e1 ? r1_wdata : r0_wdata;
                nx_byteen = e1 ? r1_byteen : r0_byteen;
                model_last = e1;
                if (nx_we) begin
                    for (int b = 0; b < BW; b++)
                        if (nx_byteen[b]) ref_mem[nx_addr][8*b +: 8] = nx_wdata[8*b +: 8];
                end else begin
                    exp_q.push_back({32'(cyc + LAT), e1, ref_mem[nx_addr]});
                end
            end
            if (clr_start && !busy) begin
                maxdue = (exp_q.size() > 0) ? int'(exp_q[$][48:17]) : -1;
                clr_s = cyc;
                clr_c = (cyc + 1 > maxdue + 1) ? cyc + 1 : maxdue + 1;
            end
        end
        prev_rst = rst;
    endtask

    // One clock: sample at the falling edge, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
        r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d; r0_byteen = be;
    endtask

    task automatic set1(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
        r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d; r1_byteen = be;
    endtask

    task automatic idle(input int n);
        set0(1'b0, 1'b0, '0, '0, '0);
        set1(1'b0, 1'b0, '0, '0, '0);
        clr_start = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) begin
            set0(1'b1, 1'b1, 4'(i), 16'(16'h1111 * (i + 1)), 2'b11);
            step();
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, got, n_we, n_dn, n_ret, nz, found;
        logic r1_seen;
        logic [DW-1:0] rd;

        // Reset
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
        chk("reset_busy", clr_busy, 0);
        chk("reset_ctl", {ram_addren, ram_re, ram_we, ram_wclke, ram_byteen, clr_done}, 0);

        // Both requesters held valid: grants alternate starting with r0.
        for (int i = 0; i < 6; i++) begin
            set0(1'b1, 1'b0, 4'd1, '0, '0);
            set1(1'b1, 1'b0, 4'd2, '0, '0);
            step();
            chk("alt_grant", {g1, g0}, (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        idle(5);

        // Write then read back, checking exact read latency.
        set0(1'b1, 1'b1, 4'd3, 16'hA5A5, 2'b11);
        step();
        set0(1'b1, 1'b0, 4'd3, '0, '0);
        acc = cyc;
        step();
        set0(1'b0, 1'b0, '0, '0, '0);
        got = -1;
        r1_seen = 1'b0;
        rd = '0;
        for (int i = 0; i < 6; i++) begin
            if (r0_rvalid && got < 0) begin got = cyc; rd = r0_rdata; end
            if (r1_rvalid) r1_seen = 1'b1;
            step();
        end
        chk("rd_latency", got - acc, 3);
        chk("rd_data_a5a5", rd, 16'hA5A5);
        chk("r1_quiet", r1_seen, 0);

        // Byte-enable merge.
        set0(1'b1, 1'b1, 4'd7, 16'h0000, 2'b11);
        step();
        set0(1'b1, 1'b1, 4'd7, 16'hFFFF, 2'b01);
        step();
        set0(1'b1, 1'b0, 4'd7, '0, '0);
        step();
        set0(1'b0, 1'b0, '0, '0, '0);
        rd = '1;
        for (int i = 0; i < 6; i++) begin
            if (r0_rvalid) rd = r0_rdata;
            step();
        end
        chk("byteen_merge", rd, 16'h00FF);

        // Random traffic with occasional clear requests.
        for (int i = 0; i < 120; i++) begin
            set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom), 2'($urandom_range(0, 3)));
            set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom), 2'($urandom_range(0, 3)));
            clr_start = ($urandom_range(0, 19) == 0);
            step();
        end
        idle(30);

        // Clear with two reads in flight.
        fill_all();
        set0(1'b1, 1'b0, 4'd2, '0, '0);
        step();
        set0(1'b0, 1'b0, '0, '0, '0);
        set1(1'b1, 1'b0, 4'd9, '0, '0);
        clr_start = 1'b1;
        step();
        set1(1'b0, 1'b0, '0, '0, '0);
        clr_start = 1'b0;
        n_we = 0; n_dn = 0; n_ret = 0;
        for (int i = 0; i < 30; i++) begin
            if (ram_we) n_we++;
            if (clr_done) n_dn++;
            if (r0_rvalid || r1_rvalid) n_ret++;
            step();
        end
        chk("clr_writes", n_we, 16);
        chk("clr_done_cnt", n_dn, 1);
        chk("drain_returns", n_ret, 2);
        nz = 0; n_ret = 0;
        for (int i = 0; i < DEPTH + 5; i++) begin
            if (i < DEPTH) set0(1'b1, 1'b0, 4'(i), '0, '0);
            else set0(1'b0, 1'b0, '0, '0, '0);
            if (r0_rvalid) begin n_ret++; if (r0_rdata != 0) nz++; end
            step();
        end
        chk("cleared_returns", n_ret, 16);
        chk("cleared_nonzero", nz, 0);

        // clr_start while clearing is ignored.
        clr_start = 1'b1;
        step();
        n_we = 0; n_dn = 0;
        for (int i = 0; i < 30; i++) begin
            clr_start = (i == 10);
            if (ram_we) n_we++;
            if (clr_done) n_dn++;
            step();
        end
        clr_start = 1'b0;
        chk("reclr_writes", n_we, 16);
        chk("reclr_done_cnt", n_dn, 1);

        // Reset in the middle of a sweep.
        fill_all();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (ram_we && ram_addr == 4'd5) found = 1;
            else step();
        end
        chk("reached_addr5", found, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", clr_busy, 0);
        chk("abort_we", ram_we, 0);
        chk("abort_ram_rst", ram_rst, 1);
        chk("abort_done", clr_done, 0);
        n_dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_done) n_dn++;
            step();
        end
        chk("abort_no_done", n_dn, 0);
        for (int i = 0; i < DEPTH; i++) begin
            set1(1'b1, 1'b0, 4'(i), '0, '0);
            step();
        end
        idle(6);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
